// File: rtl/my_prog_loader_pkg.sv
// Shared definitions for the program-memory loader and its neighbours
// (my_CPU16v3 and the memory model use the same ADDR_W default).
//   state_t     : loader FSM states
//   ADDR_W_DEF  : byte-address width of program memory (64 bytes)
//   SOF_DEF     : start-of-frame marker byte
//   len_valid() : LEN byte range check (1 .. 2^(addr_w-1) instruction words)
package my_prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam logic [7:0]  SOF_DEF    = 8'hA5;

  // A frame may fill program memory exactly but never wrap the byte address.
  function automatic logic len_valid(input logic [7:0] len, input int unsigned addr_w);
    return (len != 8'd0) && (32'(len) <= (32'd1 << (addr_w - 1)));
  endfunction

endpackage

// File: rtl/my_prog_loader_if.sv
// Loader bus: byte-stream input (valid/ready), program-memory write port and
// CPU run/error status.
//   master : byte source / consumer side (drives IN_VALID, IN_DATA)
//   slave  : loader side (drives IN_READY, MEM_WE, MEM_ADDR, MEM_WD, RUN, ERR)
interface my_prog_loader_if
  import my_prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              IN_VALID;
  logic [7:0]        IN_DATA;
  logic              IN_READY;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_WD;
  logic              RUN;
  logic              ERR;

  modport master (
    output IN_VALID, IN_DATA,
    input  IN_READY, MEM_WE, MEM_ADDR, MEM_WD, RUN, ERR
  );

  modport slave (
    input  IN_VALID, IN_DATA,
    output IN_READY, MEM_WE, MEM_ADDR, MEM_WD, RUN, ERR
  );

endinterface

// File: rtl/my_prog_loader.sv
// my_prog_loader: write side of the instruction-memory fetch path.
// Accepts frames  SOF, LEN, 2*LEN data bytes (word high byte first), CSUM
// (XOR of the data bytes) and writes the data bytes to program memory from
// address 0. RUN is raised only after a frame with a good checksum.
//   CK   : clock, all state on posedge
//   RST  : asynchronous active-high reset
//   bus  : slave modport of my_prog_loader_if
//          IN_VALID/IN_DATA/IN_READY  byte stream (transfer = valid & ready)
//          MEM_WE/MEM_ADDR/MEM_WD     registered one-cycle write strobe
//          RUN                        CPU enable
//          ERR                        sticky frame error until next SOF
module my_prog_loader
  import my_prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter logic [7:0]  SOF    = SOF_DEF
) (
  input logic           CK,
  input logic           RST,
  my_prog_loader_if.slave bus
);

  state_t            state;
  state_t            state_next;
  logic              xfer;
  logic [7:0]        byte_in;
  logic              len_ok;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last_addr;
  logic [7:0]        csum;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wd;
  logic              run;
  logic              err;

  // No back-pressure: the loader takes a byte every cycle outside reset.
  assign bus.IN_READY = ~RST;
  assign xfer         = bus.IN_VALID & ~RST;
  assign byte_in      = bus.IN_DATA;
  assign len_ok       = len_valid(byte_in, ADDR_W);

  assign bus.MEM_WE   = mem_we;
  assign bus.MEM_ADDR = mem_addr;
  assign bus.MEM_WD   = mem_wd;
  assign bus.RUN      = run;
  assign bus.ERR      = err;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (xfer) begin
      case (state)
        ST_IDLE:  if (byte_in == SOF) state_next = ST_LEN;
        ST_LEN:   state_next = len_ok ? ST_DATA : ST_ERROR;
        ST_DATA:  if (addr == last_addr) state_next = ST_CSUM;
        ST_CSUM:  state_next = (byte_in == csum) ? ST_DONE : ST_ERROR;
        ST_DONE,
        ST_ERROR: if (byte_in == SOF) state_next = ST_LEN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      addr      <= '0;
      last_addr <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      run       <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (xfer) begin
        case (state)
          ST_LEN: begin
            if (len_ok) begin
              // Store the final byte address (2*LEN-1) rather than LEN so the
              // DATA state only needs an equality compare; LEN = 2^(ADDR_W-1)
              // truncates to the top address of memory.
              last_addr <= ADDR_W'({byte_in, 1'b0} - 9'd1);
              addr      <= '0;
              csum      <= '0;
            end else begin
              err <= 1'b1;
              run <= 1'b0;
            end
          end
          ST_DATA: begin
            mem_we   <= 1'b1;
            mem_addr <= addr;
            mem_wd   <= byte_in;
            csum     <= csum ^ byte_in;
            addr     <= addr + 1'b1;
          end
          ST_CSUM: begin
            if (byte_in == csum) run <= 1'b1;
            else                 err <= 1'b1;
          end
          ST_DONE,
          ST_ERROR: begin
            if (byte_in == SOF) begin
              run <= 1'b0;
              err <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_my_prog_loader.sv
// Self-checking bench for my_prog_loader: directed frame scenarios plus
// randomized frames, checked against a frame-level reference (expected write
// per data byte, expected RUN/ERR per frame outcome, expected memory image).
module tb_my_prog_loader;
  import my_prog_loader_pkg::*;

  localparam int unsigned AW = 6;

  logic CK  = 1'b0;
  logic RST = 1'b1;

  my_prog_loader_if #(.ADDR_W(AW)) bus ();

  my_prog_loader #(.ADDR_W(AW), .SOF(8'hA5)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CK = ~CK;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [7:0] obs_mem [64];
  logic [7:0] ref_mem [64];
  logic [7:0] fd      [64];

  // Program memory as the CPU would see it: written on the edge the strobe is seen.
  always @(posedge CK) begin
    if (bus.MEM_WE) obs_mem[bus.MEM_ADDR] <= bus.MEM_WD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one byte for exactly one clock edge; returns at the next falling edge.
  task automatic send(input logic [7:0] b);
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = b;
    @(negedge CK);
    bus.IN_VALID = 1'b0;
  endtask

  task automatic gap();
    @(negedge CK);
    chk("gap_we", 32'(bus.MEM_WE), 32'd0);
  endtask

  task automatic fill_random(input int unsigned nbytes);
    for (int unsigned i = 0; i < nbytes; i++) fd[i] = 8'($urandom);
  endtask

  // Full frame of len words from fd[]; bad flips the checksum, toggle idles
  // IN_VALID before every odd data byte.
  task automatic send_frame(input int unsigned len, input bit bad, input bit toggle);
    logic [7:0] cs;
    cs = 8'h00;
    send(8'hA5);
    chk("sof_run", 32'(bus.RUN), 32'd0);
    chk("sof_err", 32'(bus.ERR), 32'd0);
    chk("sof_we", 32'(bus.MEM_WE), 32'd0);
    send(8'(len));
    chk("len_we", 32'(bus.MEM_WE), 32'd0);
    chk("len_err", 32'(bus.ERR), 32'd0);
    for (int unsigned i = 0; i < 2 * len; i++) begin
      if (toggle && (i % 2 == 1)) gap();
      send(fd[i]);
      chk("data_we", 32'(bus.MEM_WE), 32'd1);
      chk("data_addr", 32'(bus.MEM_ADDR), i);
      chk("data_wd", 32'(bus.MEM_WD), 32'(fd[i]));
      chk("data_run", 32'(bus.RUN), 32'd0);
      ref_mem[i] = fd[i];
      cs = cs ^ fd[i];
    end
    send(bad ? (cs ^ 8'h01) : cs);
    chk("csum_we", 32'(bus.MEM_WE), 32'd0);
    chk("csum_run", 32'(!bad), 32'(bus.RUN) ^ 32'd0);
    chk("csum_err", 32'(bus.ERR), 32'(bad));
  endtask

  task automatic bad_len(input logic [7:0] len);
    send(8'hA5);
    chk("blen_sof_err", 32'(bus.ERR), 32'd0);
    send(len);
    chk("blen_err", 32'(bus.ERR), 32'd1);
    chk("blen_run", 32'(bus.RUN), 32'd0);
    chk("blen_we", 32'(bus.MEM_WE), 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      send(8'($urandom_range(0, 8'hA4)));
      chk("blen_discard_we", 32'(bus.MEM_WE), 32'd0);
      chk("blen_discard_err", 32'(bus.ERR), 32'd1);
    end
  endtask

  initial begin
    int unsigned mism;
    int unsigned len;
    bit          bad;
    bit          tog;
    logic [7:0]  garbage [3];

    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'h00;

    // Reset values while RST is held.
    #1;
    chk("rst_ready", 32'(bus.IN_READY), 32'd0);
    chk("rst_we", 32'(bus.MEM_WE), 32'd0);
    chk("rst_addr", 32'(bus.MEM_ADDR), 32'd0);
    chk("rst_wd", 32'(bus.MEM_WD), 32'd0);
    chk("rst_run", 32'(bus.RUN), 32'd0);
    chk("rst_err", 32'(bus.ERR), 32'd0);
    repeat (2) @(negedge CK);
    RST = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.IN_READY), 32'd1);
    @(negedge CK);

    // Garbage before SOF is discarded.
    garbage[0] = 8'h00; garbage[1] = 8'hFF; garbage[2] = 8'h12;
    for (int unsigned i = 0; i < 3; i++) begin
      send(garbage[i]);
      chk("garbage_we", 32'(bus.MEM_WE), 32'd0);
      chk("garbage_run", 32'(bus.RUN), 32'd0);
    end

    // Known three-instruction program.
    fd[0] = 8'h20; fd[1] = 8'hCF; fd[2] = 8'h21;
    fd[3] = 8'hCF; fd[4] = 8'h00; fd[5] = 8'hA1;
    send_frame(3, 1'b0, 1'b0);
    send(8'h33);
    chk("done_discard_we", 32'(bus.MEM_WE), 32'd0);
    chk("done_discard_run", 32'(bus.RUN), 32'd1);

    // Same frame with a corrupted checksum, then recovery.
    send_frame(3, 1'b1, 1'b0);
    send(8'h00);
    chk("err_sticky", 32'(bus.ERR), 32'd1);
    chk("err_run", 32'(bus.RUN), 32'd0);
    fill_random(10);
    send_frame(5, 1'b0, 1'b0);

    // LEN range boundaries.
    bad_len(8'd0);
    bad_len(8'd33);
    fill_random(64);
    send_frame(32, 1'b0, 1'b0);

    // Gappy source.
    fill_random(14);
    send_frame(7, 1'b0, 1'b1);

    // Reset in the middle of the data phase, with a strobe pending.
    send(8'hA5);
    send(8'd4);
    for (int unsigned i = 0; i < 3; i++) send(8'($urandom));
    chk("pre_rst_we", 32'(bus.MEM_WE), 32'd1);
    RST = 1'b1;
    #1;
    chk("mid_rst_we", 32'(bus.MEM_WE), 32'd0);
    chk("mid_rst_addr", 32'(bus.MEM_ADDR), 32'd0);
    chk("mid_rst_ready", 32'(bus.IN_READY), 32'd0);
    chk("mid_rst_run", 32'(bus.RUN), 32'd0);
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = 8'h55;
    @(negedge CK);
    chk("in_rst_we", 32'(bus.MEM_WE), 32'd0);
    bus.IN_VALID = 1'b0;
    RST = 1'b0;
    @(negedge CK);
    fill_random(16);
    send_frame(8, 1'b0, 1'b0);

    // Reload from DONE.
    fill_random(4);
    send_frame(2, 1'b0, 1'b0);

    // Randomized frames.
    for (int unsigned f = 0; f < 6; f++) begin
      len = $urandom_range(1, 32);
      bad = 1'($urandom_range(0, 1));
      tog = 1'($urandom_range(0, 1));
      fill_random(2 * len);
      send_frame(len, bad, tog);
      if ($urandom_range(0, 1) == 1) gap();
    end

    // Whole memory image: the 32-word frame wrote every byte at least once.
    mism = 0;
    for (int unsigned i = 0; i < 64; i++)
      if (obs_mem[i] !== ref_mem[i]) mism++;
    chk("mem_image_mismatches", mism, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
